// File: rtl/memory_access_pkg.sv
// Shared types for the MIPS memory stage: pipeline records, data-bus structs,
// opcode constants and the memory FSM state encoding.
package memory_access_pkg;

  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2} msize_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DATA = 2'd2} mem_state_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] valE;
    logic [31:0] valB;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
  } plr_m;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] valE;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
  } plr_w;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  function automatic plr_w to_w(input plr_m m);
    plr_w w;
    w.opcode = m.opcode;
    w.funct  = m.funct;
    w.valE   = m.valE;
    w.dstE   = m.dstE;
    w.dstM   = m.dstM;
    return w;
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/memory_access_store_encoder.sv
// Combinational request encoder: classifies the opcode and builds the bus
// size, byte strobe and lane-replicated write data for an access.
module store_encoder
  import memory_access_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_valB,
  output msize_t      o_size,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_data,
  output logic        o_is_mem,
  output logic        o_misaligned
);

  always_comb begin
    o_size       = MSIZE1;
    o_strobe     = 4'b0000;
    o_data       = i_valB;
    o_is_mem     = 1'b0;
    o_misaligned = 1'b0;
    case (i_opcode)
      OP_LW, OP_SW: begin
        o_is_mem     = 1'b1;
        o_size       = MSIZE4;
        o_misaligned = |i_addr;
        if (i_opcode == OP_SW) o_strobe = 4'b1111;
      end
      OP_LH, OP_LHU, OP_SH: begin
        o_is_mem     = 1'b1;
        o_size       = MSIZE2;
        o_misaligned = i_addr[0];
        o_data       = {2{i_valB[15:0]}};
        if (i_opcode == OP_SH) o_strobe = 4'b0011 << {i_addr[1], 1'b0};
      end
      OP_LB, OP_LBU, OP_SB: begin
        o_is_mem = 1'b1;
        o_size   = MSIZE1;
        o_data   = {4{i_valB[7:0]}};
        if (i_opcode == OP_SB) o_strobe = 4'b0001 << i_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MIPS memory stage: issues one data-bus transaction per load/store, stalls
// upstream until it completes, and registers the record and raw load word for WB.
module memory_access
  import memory_access_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int DEBUG_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  plr_m                   r_M,
  input  logic                   m_valid,
  output dbus_req_t              dreq,
  input  dbus_resp_t             dresp,
  output logic                   stall_M,
  output plr_w                   r_W,
  output logic [31:0]            ld_word,
  output logic                   misalign,
  output logic [DEBUG_CNT_W-1:0] stall_cnt,
  output logic [DEBUG_CNT_W-1:0] txn_cnt,
  output mem_state_t             o_dbg_state
);

  localparam logic [DEBUG_CNT_W-1:0] CNT_ONE = {{(DEBUG_CNT_W-1){1'b0}}, 1'b1};

  mem_state_t r_state, w_next;
  dbus_req_t  r_req, w_req_new;
  plr_w       r_hold, w_cur, w_pass;
  logic [31:0] r_ld_word;
  logic        r_misalign;
  logic [DEBUG_CNT_W-1:0] r_stall_cnt, r_txn_cnt;

  msize_t      w_size;
  logic [3:0]  w_strobe;
  logic [31:0] w_data;
  logic        w_is_mem, w_mis_raw, w_mis, w_access, w_stall, w_complete;

  store_encoder u_enc (
    .i_opcode     (r_M.opcode),
    .i_addr       (r_M.valE[1:0]),
    .i_valB       (r_M.valB),
    .o_size       (w_size),
    .o_strobe     (w_strobe),
    .o_data       (w_data),
    .o_is_mem     (w_is_mem),
    .o_misaligned (w_mis_raw)
  );

  assign w_mis    = ALIGN_CHECK && m_valid && w_is_mem && w_mis_raw;
  assign w_access = m_valid && w_is_mem && !w_mis;

  always_comb begin
    w_req_new.valid  = 1'b1;
    w_req_new.addr   = (w_size == MSIZE4) ? {r_M.valE[31:2], 2'b00} : r_M.valE;
    w_req_new.size   = w_size;
    w_req_new.strobe = w_strobe;
    w_req_new.data   = w_data;
  end

  // Dropped misaligned accesses still retire, but must not write any register.
  always_comb begin
    w_pass = to_w(r_M);
    if (w_mis) begin
      w_pass.dstE = 5'd0;
      w_pass.dstM = 5'd0;
    end
  end

  // Once issued, completion uses the captured record so upstream changes are ignored.
  assign w_cur = (r_state == S_IDLE) ? to_w(r_M) : r_hold;

  always_comb begin
    w_next     = r_state;
    dreq       = '0;
    w_stall    = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          dreq = w_req_new;
          if (dresp.addr_ok && dresp.data_ok) begin
            w_complete = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_next  = dresp.addr_ok ? S_DATA : S_REQ;
          end
        end
      end
      S_REQ: begin
        dreq = r_req;
        if (dresp.addr_ok && dresp.data_ok) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (dresp.addr_ok) w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (dresp.data_ok) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_hold      <= '0;
      r_W         <= '0;
      r_ld_word   <= '0;
      r_misalign  <= 1'b0;
      r_stall_cnt <= '0;
      r_txn_cnt   <= '0;
    end else begin
      r_state    <= w_next;
      r_misalign <= (r_state == S_IDLE) && w_mis;
      if ((r_state == S_IDLE) && w_access) begin
        r_req  <= w_req_new;
        r_hold <= to_w(r_M);
      end
      if (w_stall) begin
        r_W       <= '0;
        r_ld_word <= '0;
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else if (w_complete) begin
        r_W       <= w_cur;
        r_ld_word <= is_load(w_cur.opcode) ? dresp.data : 32'h0;
        r_txn_cnt <= r_txn_cnt + CNT_ONE;
      end else if (m_valid) begin
        r_W       <= w_pass;
        r_ld_word <= '0;
      end else begin
        r_W       <= '0;
        r_ld_word <= '0;
      end
    end
  end

  assign stall_M     = w_stall;
  assign ld_word     = r_ld_word;
  assign misalign    = r_misalign;
  assign stall_cnt   = r_stall_cnt;
  assign txn_cnt     = r_txn_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed vector table, hand-written
// reset/back-to-back sequences and randomized ops against a behavioural model.
module tb_memory_access;
  import memory_access_pkg::*;

  logic       clk;
  logic       reset;
  plr_m       r_M;
  logic       m_valid;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       stall_M;
  plr_w       r_W;
  logic [31:0] ld_word;
  logic       misalign;
  logic [15:0] stall_cnt, txn_cnt;
  mem_state_t o_dbg_state;

  memory_access #(.ALIGN_CHECK(1'b1), .DEBUG_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .r_M(r_M), .m_valid(m_valid), .dreq(dreq),
    .dresp(dresp), .stall_M(stall_M), .r_W(r_W), .ld_word(ld_word),
    .misalign(misalign), .stall_cnt(stall_cnt), .txn_cnt(txn_cnt),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic        acc;
    logic        mis;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] valE;
    logic [31:0] valB;
    int          a_lat;
    int          d_lat;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_txn = 0;
  logic [85:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // behavioural reference: access width from opcode, then plain arithmetic
  function automatic int op_bytes(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 0;
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] valE,
                                 input logic [31:0] valB);
    exp_t e;
    int   n;
    n = op_bytes(op);
    e.acc = 1'b0; e.mis = 1'b0; e.addr = 32'h0; e.size = MSIZE1;
    e.strobe = 4'h0; e.data = 32'h0;
    if (n != 0) begin
      e.mis  = (valE % n) != 0;
      e.acc  = !e.mis;
      e.addr = (n == 4) ? valE - (valE % 4) : valE;
      e.size = (n == 1) ? MSIZE1 : (n == 2) ? MSIZE2 : MSIZE4;
      if (op_store(op)) e.strobe = 4'(((1 << n) - 1) << (valE % 4));
      e.data = (n == 1) ? valB[7:0] * 32'h01010101 :
               (n == 2) ? valB[15:0] * 32'h00010001 : valB;
    end
    return e;
  endfunction

  function automatic exp_t mk_e(input logic acc, input logic mis, input logic [31:0] addr,
                                input msize_t size, input logic [3:0] strobe,
                                input logic [31:0] data);
    exp_t e;
    e.acc = acc; e.mis = mis; e.addr = addr; e.size = size;
    e.strobe = strobe; e.data = data;
    return e;
  endfunction

  function automatic plr_w mk_w(input plr_m m, input logic drop_dst);
    plr_w w;
    w.opcode = m.opcode;
    w.funct  = m.funct;
    w.valE   = m.valE;
    w.dstE   = drop_dst ? 5'd0 : m.dstE;
    w.dstM   = drop_dst ? 5'd0 : m.dstM;
    return w;
  endfunction

  // driver: one instruction through the stage with a scripted slave
  task automatic run_op(input plr_m m, input int a_lat, input int d_lat,
                        input logic [31:0] rdata, input exp_t e);
    int          last;
    logic [85:0] got;
    logic        is_ld;
    is_ld = (op_bytes(m.opcode) != 0) && !op_store(m.opcode);
    last  = e.acc ? a_lat + d_lat : 0;
    @(negedge clk);
    r_M = m;
    m_valid = 1'b1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      dresp.addr_ok = e.acc && (k == a_lat);
      dresp.data_ok = e.acc && (k == last);
      dresp.data    = dresp.data_ok ? rdata : $urandom;
      #1;
      chk("req_valid", dreq.valid, e.acc && (k <= a_lat));
      if (e.acc && (k <= a_lat)) begin
        chk("req_addr", dreq.addr, e.addr);
        chk("req_size", dreq.size, e.size);
        chk("req_strobe", dreq.strobe, e.strobe);
        if (op_store(m.opcode)) chk("req_data", dreq.data, e.data);
      end
      chk("stall_M", stall_M, k < last);
      if (k < last && exp_stall != 16'hFFFF) exp_stall++;
      if (k == last) begin
        exp_q.push_back({mk_w(m, e.mis), (is_ld && e.acc) ? rdata : 32'h0});
        if (e.acc) exp_txn++;
      end
      @(posedge clk);
      #1;
      if (k < last) begin
        chk("rW_bubble", r_W, 54'h0);
      end else begin
        got = exp_q.pop_front();
        chk("rW", r_W, got[85:32]);
        chk("ld_word", ld_word, got[31:0]);
        chk("misalign", misalign, e.mis);
        chk("txn_cnt", txn_cnt, exp_txn[15:0]);
        chk("stall_cnt", stall_cnt, exp_stall[15:0]);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    m_valid = 1'b0;
    r_M = {$urandom, $urandom, $urandom, $urandom};
    dresp = '0;
    #1;
    chk("idle_req_valid", dreq.valid, 1'b0);
    chk("idle_stall", stall_M, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_rW", r_W, 54'h0);
    chk("idle_ld_word", ld_word, 32'h0);
  endtask

  function automatic plr_m mk_m(input logic [5:0] op, input logic [31:0] valE,
                                input logic [31:0] valB, input logic [4:0] de,
                                input logic [4:0] dm);
    plr_m m;
    m.opcode = op; m.funct = 6'(op + 6'd5); m.valE = valE; m.valB = valB;
    m.dstE = de; m.dstM = dm;
    return m;
  endfunction

  vec_t tbl[10];
  logic [5:0] ops[10];

  initial begin
    tbl[0] = '{OP_ADDIU, 32'h0000_1234, 32'h0, 0, 0, 32'h0,
               mk_e(1'b0, 1'b0, 32'h0, MSIZE1, 4'h0, 32'h0)};
    tbl[1] = '{OP_LW, 32'h0000_1000, 32'h0, 0, 0, 32'hDEAD_BEEF,
               mk_e(1'b1, 1'b0, 32'h0000_1000, MSIZE4, 4'h0, 32'h0)};
    tbl[2] = '{OP_SB, 32'h0000_2003, 32'h0000_00A5, 2, 3, 32'h0,
               mk_e(1'b1, 1'b0, 32'h0000_2003, MSIZE1, 4'b1000, 32'hA5A5_A5A5)};
    tbl[3] = '{OP_LH, 32'h0000_3001, 32'h0, 0, 0, 32'h0,
               mk_e(1'b0, 1'b1, 32'h0, MSIZE1, 4'h0, 32'h0)};
    tbl[4] = '{OP_SH, 32'h0000_4002, 32'h1234_BEEF, 1, 0, 32'h0,
               mk_e(1'b1, 1'b0, 32'h0000_4002, MSIZE2, 4'b1100, 32'hBEEF_BEEF)};
    tbl[5] = '{OP_LW, 32'h0000_5000, 32'h0, 0, 1, 32'h1122_3344,
               mk_e(1'b1, 1'b0, 32'h0000_5000, MSIZE4, 4'h0, 32'h0)};
    tbl[6] = '{OP_SW, 32'h0000_5004, 32'hCAFE_F00D, 0, 1, 32'h0,
               mk_e(1'b1, 1'b0, 32'h0000_5004, MSIZE4, 4'b1111, 32'hCAFE_F00D)};
    tbl[7] = '{OP_LBU, 32'h0000_6001, 32'h0, 1, 2, 32'h0000_FF00,
               mk_e(1'b1, 1'b0, 32'h0000_6001, MSIZE1, 4'h0, 32'h0)};
    tbl[8] = '{OP_SW, 32'h0000_7002, 32'h5555_AAAA, 0, 0, 32'h0,
               mk_e(1'b0, 1'b1, 32'h0, MSIZE1, 4'h0, 32'h0)};
    tbl[9] = '{OP_LHU, 32'h0000_8002, 32'h0, 3, 0, 32'hABCD_0000,
               mk_e(1'b1, 1'b0, 32'h0000_8002, MSIZE2, 4'h0, 32'h0)};
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADDIU, 6'h00};

    reset = 1'b1; m_valid = 1'b0; r_M = '0; dresp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rW", r_W, 54'h0);
    chk("rst_ld_word", ld_word, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 16'h0);
    chk("rst_txn_cnt", txn_cnt, 16'h0);
    chk("rst_req_valid", dreq.valid, 1'b0);
    chk("rst_state", o_dbg_state, S_IDLE);

    // directed table, consecutive rows run back-to-back
    for (int i = 0; i < 10; i++)
      run_op(mk_m(tbl[i].op, tbl[i].valE, tbl[i].valB, 5'(i + 1), 5'(i + 10)),
             tbl[i].a_lat, tbl[i].d_lat, tbl[i].rdata, tbl[i].e);
    idle_cycle();

    // reset while waiting for data
    @(negedge clk);
    r_M = mk_m(OP_LW, 32'h0000_9000, 32'h0, 5'd1, 5'd2);
    m_valid = 1'b1;
    dresp.addr_ok = 1'b1; dresp.data_ok = 1'b0; dresp.data = 32'h0;
    #1;
    chk("rs_req_valid", dreq.valid, 1'b1);
    chk("rs_stall", stall_M, 1'b1);
    @(posedge clk);
    #1;
    chk("rs_state_data", o_dbg_state, S_DATA);
    @(negedge clk);
    dresp = '0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0;
    #1;
    chk("rs_after_valid", dreq.valid, 1'b0);
    chk("rs_after_rW", r_W, 54'h0);
    chk("rs_after_state", o_dbg_state, S_IDLE);
    chk("rs_after_txn", txn_cnt, 16'h0);
    exp_stall = 0;
    exp_txn = 0;
    run_op(mk_m(OP_LW, 32'h0000_9004, 32'h0, 5'd3, 5'd4), 0, 0, 32'h0BAD_F00D,
           model(OP_LW, 32'h0000_9004, 32'h0));

    // back-to-back LW then SW with 1-cycle slave
    run_op(mk_m(OP_LW, 32'h0000_A000, 32'h0, 5'd5, 5'd6), 0, 1, 32'h7777_8888,
           model(OP_LW, 32'h0000_A000, 32'h0));
    run_op(mk_m(OP_SW, 32'h0000_A004, 32'h1357_9BDF, 5'd7, 5'd8), 0, 1, 32'h0,
           model(OP_SW, 32'h0000_A004, 32'h1357_9BDF));

    // randomized ops against the model
    for (int n = 0; n < 150; n++) begin
      logic [5:0]  op;
      logic [31:0] va, vb;
      op = ops[$urandom_range(0, 9)];
      va = $urandom;
      vb = $urandom;
      if ($urandom_range(0, 4) == 0) idle_cycle();
      run_op(mk_m(op, va, vb, 5'($urandom), 5'($urandom)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, model(op, va, vb));
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
